// File: rtl/serv_mem_seq.sv
// serv_mem_seq: load/store sequencer between the W-bit serial datapath and a 32-bit data bus.
// Optional bus-wait abort is compiled in with `define SERV_MEM_SEQ_TIMEOUT_EN.
module serv_mem_seq #(
    parameter int W       = 8,
    parameter int TIMEOUT = 255
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req,
    input  logic          i_store,
    input  logic          i_word,
    input  logic          i_half,
    input  logic          i_signed,
    input  logic [31:0]   i_adr,
    input  logic [W-1:0]  i_rs2,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_misalign,
    output logic [W-1:0]  o_rd,
    output logic          o_rd_valid,
    output logic [1:0]    o_bytecnt,
    output logic [1:0]    o_lsb,
    output logic [31:0]   o_dbus_adr,
    output logic [31:0]   o_dbus_dat,
    output logic [3:0]    o_dbus_sel,
    output logic          o_dbus_we,
    output logic          o_dbus_cyc,
    input  logic [31:0]   i_dbus_rdt,
    input  logic          i_dbus_ack,
    output logic          o_err
);

    localparam int N = 32 / W;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] SIN  = 3'd1;
    localparam logic [2:0] BUS  = 3'd2;
    localparam logic [2:0] SOUT = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]  state;
    logic [4:0]  beat;
    logic [4:0]  bitpos;
    logic [31:0] data;
    logic [29:0] adr_hi;
    logic [1:0]  lsb;
    logic        word;
    logic        half;
    logic        sgn;
    logic        store;
    logic        misalign;
    logic        last_beat;
    logic        mis_req;
    logic        byte_ok;
    logic        fill;
    logic        timeout_hit;
    logic [3:0]  sel;

    assign bitpos    = 5'(beat * 5'(W));
    assign last_beat = (beat == 5'(N - 1));
    assign mis_req   = (i_word && (i_adr[1:0] != 2'b00)) || (!i_word && i_half && i_adr[0]);

    always_comb begin
        if (word)
            sel = 4'b1111;
        else if (half)
            sel = 4'b0011 << lsb;
        else
            sel = 4'b0001 << lsb;
    end

    // Bytes beyond the access size are replaced by the extension bit of the top valid byte.
    assign byte_ok = word || (half && !bitpos[4]) || (bitpos[4:3] == 2'b00);
    assign fill    = sgn && (half ? data[15] : data[7]);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            beat     <= '0;
            data     <= '0;
            adr_hi   <= '0;
            lsb      <= '0;
            word     <= 1'b0;
            half     <= 1'b0;
            sgn      <= 1'b0;
            store    <= 1'b0;
            misalign <= 1'b0;
        end else begin
            misalign <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req) begin
                        if (mis_req) begin
                            misalign <= 1'b1;
                        end else begin
                            adr_hi <= i_adr[31:2];
                            lsb    <= i_adr[1:0];
                            word   <= i_word;
                            half   <= i_half;
                            sgn    <= i_signed;
                            store  <= i_store;
                            beat   <= '0;
                            state  <= i_store ? SIN : BUS;
                        end
                    end
                end
                SIN: begin
                    data[bitpos +: W] <= i_rs2;
                    if (last_beat) begin
                        beat  <= '0;
                        state <= BUS;
                    end else begin
                        beat <= beat + 5'd1;
                    end
                end
                BUS: begin
                    if (i_dbus_ack) begin
                        if (!store)
                            data <= i_dbus_rdt >> {lsb, 3'b000};
                        state <= store ? DONE : SOUT;
                    end else if (timeout_hit) begin
                        state <= IDLE;
                    end
                end
                SOUT: begin
                    if (last_beat) begin
                        beat  <= '0;
                        state <= DONE;
                    end else begin
                        beat <= beat + 5'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SERV_MEM_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tcnt;
    logic          err;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tcnt <= '0;
            err  <= 1'b0;
        end else begin
            err <= timeout_hit;
            if ((state == BUS) && !timeout_hit)
                tcnt <= tcnt + 1'b1;
            else
                tcnt <= '0;
        end
    end

    assign timeout_hit = (state == BUS) && !i_dbus_ack && (tcnt == TW'(TIMEOUT - 1));
    assign o_err       = err;
`else
    assign timeout_hit = 1'b0;
    assign o_err       = 1'b0;
`endif

    assign o_busy     = (state != IDLE);
    assign o_done     = (state == DONE);
    assign o_misalign = misalign;
    assign o_rd_valid = (state == SOUT);
    assign o_rd       = (state == SOUT) ? (byte_ok ? data[bitpos +: W] : {W{fill}}) : '0;
    assign o_bytecnt  = ((state == SIN) || (state == SOUT)) ? bitpos[4:3] : 2'b00;
    assign o_lsb      = lsb;
    assign o_dbus_adr = {adr_hi, 2'b00};
    assign o_dbus_dat = data << {lsb, 3'b000};
    assign o_dbus_cyc = (state == BUS);
    assign o_dbus_sel = o_dbus_cyc ? sel : 4'b0000;
    assign o_dbus_we  = o_dbus_cyc && store;

endmodule

// File: tb/tb_serv_mem_seq.sv
// Scoreboard bench for serv_mem_seq (W=8): stimulus pushes expected bus/beat/done/misalign
// events, an independent monitor pops and compares them as the DUT produces them.
module tb_serv_mem_seq;
    localparam int W = 8;
    localparam int K_BUS = 0, K_RD = 1, K_DONE = 2, K_MIS = 3;

    typedef struct {
        int          kind;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic        we;
        logic [1:0]  lsb;
        logic [31:0] dat;
        logic [7:0]  rd;
        logic [1:0]  bc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req = 1'b0, store = 1'b0, word = 1'b0, half = 1'b0, sgn = 1'b0;
    logic [31:0]  adr = '0;
    logic [W-1:0] rs2 = '0;
    logic         busy, done, misalign, rd_valid, dbus_we, dbus_cyc, err;
    logic [W-1:0] rd;
    logic [1:0]   bytecnt, lsb_o;
    logic [31:0]  dbus_adr, dbus_dat;
    logic [3:0]   dbus_sel;
    logic [31:0]  dbus_rdt = '0;
    logic         dbus_ack = 1'b0;

    exp_t        q[$];
    int          checks = 0;
    int          passes = 0;
    int          ack_delay = 0;
    logic [31:0] rdt_next = '0;

    serv_mem_seq #(.W(W), .TIMEOUT(255)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_store(store), .i_word(word),
        .i_half(half), .i_signed(sgn), .i_adr(adr), .i_rs2(rs2),
        .o_busy(busy), .o_done(done), .o_misalign(misalign), .o_rd(rd),
        .o_rd_valid(rd_valid), .o_bytecnt(bytecnt), .o_lsb(lsb_o),
        .o_dbus_adr(dbus_adr), .o_dbus_dat(dbus_dat), .o_dbus_sel(dbus_sel),
        .o_dbus_we(dbus_we), .o_dbus_cyc(dbus_cyc), .i_dbus_rdt(dbus_rdt),
        .i_dbus_ack(dbus_ack), .o_err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    function automatic void push(int kind, logic [31:0] a, logic [3:0] s, logic w,
                                 logic [1:0] l, logic [31:0] d, logic [7:0] r, logic [1:0] b);
        exp_t e;
        e.kind = kind; e.adr = a; e.sel = s; e.we = w; e.lsb = l; e.dat = d; e.rd = r; e.bc = b;
        q.push_back(e);
    endfunction

    task automatic expect_evt(input int kind, output bit ok, output exp_t e);
        ok = 1'b0;
        if (q.size() == 0) begin
            chk($sformatf("unexpected event kind %0d", kind), 1, 0);
        end else begin
            e = q.pop_front();
            chk("event order", kind, e.kind);
            ok = (e.kind == kind);
        end
    endtask

    // Bus slave: ack after ack_delay cycles of cyc, single-cycle, with garbage rdt otherwise.
    initial begin
        int cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (dbus_ack || rst || !dbus_cyc) begin
                dbus_ack = 1'b0;
                dbus_rdt = $urandom;
                cnt = 0;
            end else if (cnt >= ack_delay) begin
                dbus_ack = 1'b1;
                dbus_rdt = rdt_next;
            end else begin
                cnt++;
            end
        end
    end

    // Monitor
    initial begin
        exp_t e;
        bit   ok;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (dbus_cyc && dbus_ack) begin
                    expect_evt(K_BUS, ok, e);
                    if (ok) begin
                        chk("bus adr/sel/we/lsb", {dbus_adr, dbus_sel, dbus_we, lsb_o},
                            {e.adr, e.sel, e.we, e.lsb});
                        if (e.we) chk("bus store data", dbus_dat, e.dat);
                    end
                end
                if (rd_valid) begin
                    expect_evt(K_RD, ok, e);
                    if (ok) chk("load beat/bytecnt", {rd, bytecnt}, {e.rd, e.bc});
                end
                if (done) expect_evt(K_DONE, ok, e);
                if (misalign) expect_evt(K_MIS, ok, e);
                if (err) chk("bus error pulse", err, 1'b0);
            end
        end
    end

    task automatic run(input int sz, input logic [31:0] a, input logic st, input logic sg,
                       input logic [31:0] d, input int dly, input bit spur);
        logic [1:0]  l;
        logic [31:0] v;
        int          nb;
        bit          mis, got;
        l   = a[1:0];
        mis = (sz == 2 && l != 2'b00) || (sz == 1 && l[0]);
        nb  = (sz == 2) ? 4 : (sz == 1) ? 2 : 1;
        if (mis) begin
            push(K_MIS, 0, 0, 0, 0, 0, 0, 0);
        end else begin
            push(K_BUS, {a[31:2], 2'b00}, 4'(((1 << nb) - 1) << l), st, l, d << (8 * l), 0, 0);
            if (!st) begin
                v = d >> (8 * l);
                for (int b = nb; b < 4; b++) v[8*b +: 8] = (sg && v[8*nb-1]) ? 8'hFF : 8'h00;
                for (int k = 0; k < 4; k++) push(K_RD, 0, 0, 0, 0, 0, v[8*k +: 8], 2'(k));
            end
            push(K_DONE, 0, 0, 0, 0, 0, 0, 0);
        end
        ack_delay = dly;
        rdt_next  = d;
        @(negedge clk);
        req = 1'b1; store = st; word = (sz == 2); half = (sz == 1); sgn = sg; adr = a;
        @(negedge clk);
        req = 1'b0; adr = $urandom; store = 1'($urandom); sgn = 1'($urandom);
        if (mis) begin
            chk("misalign: busy/cyc", {busy, dbus_cyc}, 2'b00);
            @(negedge clk);
            chk("misalign: stays idle", {busy, dbus_cyc}, 2'b00);
            return;
        end
        if (st) begin
            for (int k = 0; k < 4; k++) begin
                rs2 = d[8*k +: 8];
                req = spur && (k == 1);
                @(negedge clk);
            end
            req = 1'b0;
        end
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            if (done) begin
                got = 1'b1;
            end else begin
                req = spur && busy && ($urandom_range(0, 3) == 0);
                @(negedge clk);
                req = 1'b0;
            end
        end
        if (!got) begin
            chk("transaction completes", 0, 1);
            q.delete();
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end
    endtask

    task automatic reset_mid_bus();
        ack_delay = 1000;
        @(negedge clk);
        req = 1'b1; word = 1'b1; half = 1'b0; store = 1'b0; adr = 32'h0000_0300;
        @(negedge clk);
        req = 1'b0;
        chk("cyc up in bus", dbus_cyc, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("reset drops cyc/busy", {dbus_cyc, busy}, 2'b00);
        chk("reset clears bus adr", dbus_adr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        ack_delay = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset control outputs", {busy, done, misalign, rd, rd_valid, bytecnt, lsb_o,
                                      dbus_cyc, dbus_we, dbus_sel, err}, 0);
        chk("reset bus adr/dat", {dbus_adr, dbus_dat}, 0);
        rst = 1'b0;
        run(2, 32'h0000_0100, 1'b0, 1'b0, 32'h8765_4321, 3, 1'b0);
        run(0, 32'h0000_0103, 1'b0, 1'b1, 32'h8012_3456, 1, 1'b0);
        run(0, 32'h0000_0103, 1'b0, 1'b0, 32'h8012_3456, 0, 1'b0);
        run(1, 32'h0000_0202, 1'b1, 1'b0, 32'hA5A5_1234, 2, 1'b1);
        run(2, 32'h0000_0101, 1'b0, 1'b0, 32'h1111_1111, 0, 1'b0);
        run(1, 32'h0000_0103, 1'b1, 1'b0, 32'h2222_2222, 0, 1'b0);
        run(1, 32'h0000_0102, 1'b0, 1'b1, 32'h8001_7FFF, 0, 1'b1);
        run(0, 32'h0000_0001, 1'b1, 1'b0, 32'hCAFE_F00D, 1, 1'b0);
        reset_mid_bus();
        run(2, 32'h0000_0104, 1'b1, 1'b0, 32'hDEAD_BEEF, 0, 1'b0);
        for (int t = 0; t < 40; t++)
            run($urandom_range(0, 2), $urandom, 1'($urandom), 1'($urandom), $urandom,
                $urandom_range(0, 3), 1'($urandom));
        repeat (5) @(negedge clk);
        chk("scoreboard drained", q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
